// File: rtl/trax_move_scanner.sv
// Sequential Trax valid-move generator: scans an m x n board region, streams legal moves over valid/ready.
// Optional TRAX_FIRST_MOVE_EN: an empty board emits the opening moves {plus,0,0},{slash,0,0}.
module trax_move_scanner #(
    parameter int ROW_W      = 10,
    parameter int COL_W      = 10,
    parameter int CELL_W     = 3,
    parameter int MAX_K_BITS = 8,
    parameter int MAX_MOVES  = 203
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [ROW_W-1:0]         m,
    input  logic [COL_W-1:0]         n,
    output logic                     rd_en,
    output logic [ROW_W-1:0]         rd_row,
    output logic [COL_W-1:0]         rd_col,
    input  logic [CELL_W-1:0]        rd_data,
    output logic                     mv_valid,
    input  logic                     mv_ready,
    output logic [2+COL_W+ROW_W-1:0] mv_data,
    output logic [MAX_K_BITS-1:0]    k,
    output logic                     busy,
    output logic                     done,
    output logic                     overflow
);

    typedef enum logic [3:0] {
        S_IDLE, S_RD_CUR, S_RD_UP, S_RD_RT, S_RD_DN, S_RD_LF,
        S_EVAL, S_EMIT, S_NEXT, S_OPEN, S_DONE
    } state_t;

    localparam logic [1:0]       T_PLUS   = 2'b01;
    localparam logic [1:0]       T_SLASH  = 2'b10;
    localparam logic [1:0]       T_BSLASH = 2'b11;
    localparam logic [ROW_W-1:0] R_ONE    = 1;
    localparam logic [COL_W-1:0] C_ONE    = 1;

    state_t                state_q, state_d;
    logic [ROW_W-1:0]      m_q, r_q;
    logic [COL_W-1:0]      n_q, c_q;
    logic                  nb_up, nb_rt, nb_dn;
    logic [1:0]            t0_q, t1_q, t2_q, num_q, idx_q;
    logic [MAX_K_BITS-1:0] k_q;
    logic                  ovf_q;
`ifdef TRAX_FIRST_MOVE_EN
    logic                  saw_occ;
`endif

    logic       occ, has_up, has_rt, has_dn, has_lf, lf, last_cell, accept;
    logic [2:0] cnt;
    logic [1:0] cls_num, cls_t0, cls_t1, cls_t2, cur_type;

    assign occ       = (rd_data != '0);
    assign has_up    = (r_q != '0);
    assign has_rt    = (c_q != n_q - C_ONE);
    assign has_dn    = (r_q != m_q - R_ONE);
    assign has_lf    = (c_q != '0);
    assign last_cell = !has_dn && !has_rt;
    assign accept    = mv_valid && mv_ready;

    // Left neighbour is consumed straight off rd_data in EVAL; the other three were captured earlier.
    always_comb begin
        lf      = has_lf && occ;
        cnt     = 3'(nb_up) + 3'(nb_rt) + 3'(nb_dn) + 3'(lf);
        cls_num = '0;
        cls_t0  = T_PLUS;
        cls_t1  = T_SLASH;
        cls_t2  = T_BSLASH;
        if (cnt == 3'd1) begin
            cls_num = 2'd3;
        end else if (cnt == 3'd2) begin
            cls_num = 2'd2;
            case ({nb_up, nb_rt, nb_dn, lf})
                4'b1100: begin cls_t0 = T_PLUS;   cls_t1 = T_SLASH;  end
                4'b1010: begin cls_t0 = T_BSLASH; cls_t1 = T_SLASH;  end
                4'b1001: begin cls_t0 = T_PLUS;   cls_t1 = T_BSLASH; end
                4'b0110: begin cls_t0 = T_PLUS;   cls_t1 = T_BSLASH; end
                4'b0101: begin cls_t0 = T_BSLASH; cls_t1 = T_SLASH;  end
                default: begin cls_t0 = T_PLUS;   cls_t1 = T_SLASH;  end
            endcase
        end
    end

    always_comb begin
        case (idx_q)
            2'd0:    cur_type = t0_q;
            2'd1:    cur_type = t1_q;
            default: cur_type = t2_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        rd_en    = 1'b0;
        rd_row   = '0;
        rd_col   = '0;
        mv_valid = 1'b0;
        mv_data  = '0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = (m == '0 || n == '0) ? S_DONE : S_RD_CUR;
            end
            S_RD_CUR: begin
                rd_en   = 1'b1;
                rd_row  = r_q;
                rd_col  = c_q;
                state_d = S_RD_UP;
            end
            S_RD_UP: begin
                if (occ) begin
                    state_d = S_NEXT;
                end else begin
                    rd_en   = has_up;
                    rd_row  = has_up ? r_q - R_ONE : '0;
                    rd_col  = has_up ? c_q : '0;
                    state_d = S_RD_RT;
                end
            end
            S_RD_RT: begin
                rd_en   = has_rt;
                rd_row  = has_rt ? r_q : '0;
                rd_col  = has_rt ? c_q + C_ONE : '0;
                state_d = S_RD_DN;
            end
            S_RD_DN: begin
                rd_en   = has_dn;
                rd_row  = has_dn ? r_q + R_ONE : '0;
                rd_col  = has_dn ? c_q : '0;
                state_d = S_RD_LF;
            end
            S_RD_LF: begin
                rd_en   = has_lf;
                rd_row  = has_lf ? r_q : '0;
                rd_col  = has_lf ? c_q - C_ONE : '0;
                state_d = S_EVAL;
            end
            S_EVAL: begin
                state_d = (cls_num == '0) ? S_NEXT : S_EMIT;
            end
            S_EMIT: begin
                mv_valid = 1'b1;
                mv_data  = {cur_type, c_q, r_q};
                if (mv_ready && idx_q == num_q - 2'd1) state_d = S_NEXT;
            end
            S_NEXT: begin
                if (!last_cell) begin
                    state_d = S_RD_CUR;
                end else begin
`ifdef TRAX_FIRST_MOVE_EN
                    state_d = saw_occ ? S_DONE : S_OPEN;
`else
                    state_d = S_DONE;
`endif
                end
            end
            S_OPEN: begin
                mv_valid = 1'b1;
                mv_data  = {(idx_q[0] ? T_SLASH : T_PLUS), {COL_W{1'b0}}, {ROW_W{1'b0}}};
                if (mv_ready && idx_q[0]) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            m_q     <= '0;
            n_q     <= '0;
            r_q     <= '0;
            c_q     <= '0;
            nb_up   <= 1'b0;
            nb_rt   <= 1'b0;
            nb_dn   <= 1'b0;
            t0_q    <= '0;
            t1_q    <= '0;
            t2_q    <= '0;
            num_q   <= '0;
            idx_q   <= '0;
            k_q     <= '0;
            ovf_q   <= 1'b0;
`ifdef TRAX_FIRST_MOVE_EN
            saw_occ <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: if (start) begin
                    m_q   <= m;
                    n_q   <= n;
                    r_q   <= '0;
                    c_q   <= '0;
                    k_q   <= '0;
                    ovf_q <= 1'b0;
`ifdef TRAX_FIRST_MOVE_EN
                    saw_occ <= 1'b0;
`endif
                end
`ifdef TRAX_FIRST_MOVE_EN
                S_RD_UP: if (occ) saw_occ <= 1'b1;
`endif
                S_RD_RT: nb_up <= has_up && occ;
                S_RD_DN: nb_rt <= has_rt && occ;
                S_RD_LF: nb_dn <= has_dn && occ;
                S_EVAL: begin
                    t0_q  <= cls_t0;
                    t1_q  <= cls_t1;
                    t2_q  <= cls_t2;
                    num_q <= cls_num;
                    idx_q <= '0;
                end
                S_NEXT: begin
                    idx_q <= '0;
                    if (has_rt) begin
                        c_q <= c_q + C_ONE;
                    end else if (has_dn) begin
                        c_q <= '0;
                        r_q <= r_q + R_ONE;
                    end
                end
                default: ;
            endcase
            // Moves past capacity still complete their handshake; only the count saturates.
            if (accept) begin
                idx_q <= idx_q + 2'd1;
                if (k_q == MAX_K_BITS'(MAX_MOVES)) ovf_q <= 1'b1;
                else                               k_q   <= k_q + 1'b1;
            end
        end
    end

    assign k        = k_q;
    assign overflow = ovf_q;
    assign busy     = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done     = (state_q == S_DONE);

endmodule
